// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: per-word error code layout and flow-control states.
package uart_pkg;

  localparam int ERR_BREAK  = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_FRAME  = 2;

  typedef struct packed {
    logic frame;
    logic parity;
    logic brk;
  } rx_err_t;

  typedef enum logic {
    ACCEPT   = 1'b0,
    THROTTLE = 1'b1
  } flow_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The caller qualifies wr_i/rd_i; no internal full/empty guarding.
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     rd_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wrPtr_d = wr_i ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d = rd_i ? rdPtr_q + AW'(1) : rdPtr_q;
    count_d = count_q + CW'(wr_i) - CW'(rd_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_i) mem[wrPtr_q] <= wdata_i;
  end

  assign rdata_o = mem[rdPtr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: captures receiver words into a FIFO, serves the host over
// valid/ready, tracks error/overrun status and throttles the remote end through RTS.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int HI_WATER   = 12,
  parameter int LO_WATER   = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [DATA_BITS-1:0]          Rx_Data_In,
  input  logic [2:0]                    Rx_Error_In,
  input  logic                          Data_Rdy_In,
  input  logic                          Rx_Rts_In,
  output logic                          RTS,
  output logic [DATA_BITS-1:0]          Host_Data_Out,
  output logic [2:0]                    Host_Err_Out,
  output logic                          Host_Valid,
  input  logic                          Host_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
  output logic [2:0]                    Err_Flags,
  output logic [CNT_W-1:0]              Err_Count,
  output logic [CNT_W-1:0]              Drop_Count,
  output logic                          Overrun,
  input  logic                          Clr_Status
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int W  = DATA_BITS + 3;

  logic              dataRdy_q;
  logic              push, pop, wrEn, drop, anyErr;
  logic              full, empty;
  logic [CW-1:0]     count, countNext;
  logic [W-1:0]      rdData;
  rx_err_t           errIn;

  flow_state_t       state_q, state_d;
  logic              rts_q;
  logic [2:0]        errFlags_q, errFlags_d;
  logic [CNT_W-1:0]  errCount_q, errCount_d;
  logic [CNT_W-1:0]  dropCount_q, dropCount_d;
  logic              overrun_q, overrun_d;

  assign errIn  = Rx_Error_In;
  assign anyErr = errIn.brk | errIn.parity | errIn.frame;

  // A full FIFO still takes a word when the host frees a slot on the same edge.
  assign push      = Data_Rdy_In && !dataRdy_q;
  assign pop       = !empty && Host_Ready;
  assign wrEn      = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign countNext = count + CW'(wrEn) - CW'(pop);

  uart_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .wr_i    (wrEn),
    .wdata_i ({Rx_Error_In, Rx_Data_In}),
    .rd_i    (pop),
    .rdata_o (rdData),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Clear first, then layer the current capture on top so a same-cycle capture survives.
  always_comb begin
    errFlags_d  = Clr_Status ? '0 : errFlags_q;
    errCount_d  = Clr_Status ? '0 : errCount_q;
    dropCount_d = Clr_Status ? '0 : dropCount_q;
    overrun_d   = Clr_Status ? 1'b0 : overrun_q;
    if (push) begin
      errFlags_d = errFlags_d | Rx_Error_In;
      if (anyErr && errCount_d != '1) errCount_d = errCount_d + CNT_W'(1);
    end
    if (drop) begin
      overrun_d = 1'b1;
      if (dropCount_d != '1) dropCount_d = dropCount_d + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCEPT:   if (countNext >= CW'(HI_WATER)) state_d = THROTTLE;
      THROTTLE: if (countNext <= CW'(LO_WATER)) state_d = ACCEPT;
      default:  state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      dataRdy_q   <= 1'b0;
      state_q     <= ACCEPT;
      rts_q       <= 1'b0;
      errFlags_q  <= '0;
      errCount_q  <= '0;
      dropCount_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      dataRdy_q   <= Data_Rdy_In;
      state_q     <= state_d;
      rts_q       <= (state_q == ACCEPT) && Rx_Rts_In;
      errFlags_q  <= errFlags_d;
      errCount_q  <= errCount_d;
      dropCount_q <= dropCount_d;
      overrun_q   <= overrun_d;
    end
  end

  assign RTS           = rts_q;
  assign Host_Data_Out = rdData[DATA_BITS-1:0];
  assign Host_Err_Out  = rdData[W-1:DATA_BITS];
  assign Host_Valid    = !empty;
  assign Fifo_Count    = count;
  assign Err_Flags     = errFlags_q;
  assign Err_Count     = errCount_q;
  assign Drop_Count    = dropCount_q;
  assign Overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: scoreboard queue of expected words plus
// model-tracked status, flow-control timing checks around the watermarks.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxData;
  logic [2:0]  rxErr;
  logic        dataRdy;
  logic        rxRts;
  logic        rts;
  logic [7:0]  hostData;
  logic [2:0]  hostErr;
  logic        hostValid;
  logic        hostReady;
  logic [4:0]  fifoCount;
  logic [2:0]  errFlags;
  logic [7:0]  errCount;
  logic [7:0]  dropCount;
  logic        overrun;
  logic        clrStatus;

  int          checks = 0;
  int          failures = 0;

  logic [10:0] sbQ[$];
  logic [2:0]  modelFlags = '0;
  int          modelErrCnt = 0;
  int          modelDropCnt = 0;
  logic        modelOverrun = 1'b0;

  uart_rx_ctrl dut (
    .Clk           (clk),
    .Rst           (rst),
    .Rx_Data_In    (rxData),
    .Rx_Error_In   (rxErr),
    .Data_Rdy_In   (dataRdy),
    .Rx_Rts_In     (rxRts),
    .RTS           (rts),
    .Host_Data_Out (hostData),
    .Host_Err_Out  (hostErr),
    .Host_Valid    (hostValid),
    .Host_Ready    (hostReady),
    .Fifo_Count    (fifoCount),
    .Err_Flags     (errFlags),
    .Err_Count     (errCount),
    .Drop_Count    (dropCount),
    .Overrun       (overrun),
    .Clr_Status    (clrStatus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Model update for one capture; the caller decides whether a pop happens on the same edge.
  task automatic modelCapture(input logic [7:0] d, input logic [2:0] e, input bit withPop);
    if (sbQ.size() < 16 || withPop) sbQ.push_back({e, d});
    else begin
      modelDropCnt++;
      modelOverrun = 1'b1;
    end
    modelFlags |= e;
    if (e != 3'b000) modelErrCnt++;
  endtask

  // Pushes one word with a Data_Rdy_In pulse of len cycles, then one idle cycle.
  task automatic applyStimulus(input logic [7:0] d, input logic [2:0] e, input int len);
    rxData  = d;
    rxErr   = e;
    dataRdy = 1'b1;
    modelCapture(d, e, 1'b0);
    repeat (len) @(negedge clk);
    dataRdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic popAndCheck(input string tag);
    logic [10:0] exp;
    checkOutput({tag, "_valid"}, 32'(hostValid), 32'd1);
    if (sbQ.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'(sbQ.size()), 32'd1);
    end else begin
      exp = sbQ.pop_front();
      checkOutput({tag, "_data"}, 32'(hostData), 32'(exp[7:0]));
      checkOutput({tag, "_err"},  32'(hostErr),  32'(exp[10:8]));
    end
    hostReady = 1'b1;
    @(negedge clk);
    hostReady = 1'b0;
  endtask

  task automatic drainAll(input string tag);
    int n;
    n = sbQ.size();
    for (int i = 0; i < n; i++) popAndCheck(tag);
    checkOutput({tag, "_empty_count"}, 32'(fifoCount), 32'd0);
    checkOutput({tag, "_empty_valid"}, 32'(hostValid), 32'd0);
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_flags"},   32'(errFlags),  32'(modelFlags));
    checkOutput({tag, "_errcnt"},  32'(errCount),  32'(modelErrCnt));
    checkOutput({tag, "_dropcnt"}, 32'(dropCount), 32'(modelDropCnt));
    checkOutput({tag, "_overrun"}, 32'(overrun),   32'(modelOverrun));
  endtask

  initial begin
    logic [10:0] head;
    rst = 1'b1; rxData = '0; rxErr = '0; dataRdy = 1'b0; rxRts = 1'b0;
    hostReady = 1'b0; clrStatus = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_rts", 32'(rts), 32'd0);
    checkOutput("rst_valid", 32'(hostValid), 32'd0);
    checkOutput("rst_count", 32'(fifoCount), 32'd0);
    checkStatus("rst");
    rst = 1'b0;
    rxRts = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_rts_up", 32'(rts), 32'd1);

    // Single word with a long ready pulse gives exactly one entry
    applyStimulus(8'hA5, 3'b000, 3);
    checkOutput("single_count", 32'(fifoCount), 32'd1);
    checkOutput("single_valid", 32'(hostValid), 32'd1);
    checkOutput("single_data", 32'(hostData), 32'hA5);
    popAndCheck("single_pop");
    checkOutput("single_after_count", 32'(fifoCount), 32'd0);
    checkOutput("single_after_valid", 32'(hostValid), 32'd0);

    // High watermark: RTS drops one cycle after the count reaches 12
    for (int i = 0; i < 11; i++) applyStimulus(8'(8'h10 + i), 3'b000, 1);
    checkOutput("hi_rts_11", 32'(rts), 32'd1);
    rxData = 8'h1B; rxErr = 3'b000; dataRdy = 1'b1;
    modelCapture(8'h1B, 3'b000, 1'b0);
    @(negedge clk);
    dataRdy = 1'b0;
    checkOutput("hi_count_12", 32'(fifoCount), 32'd12);
    checkOutput("hi_rts_still_up", 32'(rts), 32'd1);
    @(negedge clk);
    checkOutput("hi_rts_down", 32'(rts), 32'd0);

    // Low watermark: RTS stays low at 5, rises one cycle after 4
    for (int i = 0; i < 7; i++) popAndCheck("lo_pop");
    checkOutput("lo_count_5", 32'(fifoCount), 32'd5);
    @(negedge clk);
    checkOutput("lo_rts_at_5", 32'(rts), 32'd0);
    head = sbQ.pop_front();
    checkOutput("lo_pop8_data", 32'(hostData), 32'(head[7:0]));
    hostReady = 1'b1;
    @(negedge clk);
    hostReady = 1'b0;
    checkOutput("lo_count_4", 32'(fifoCount), 32'd4);
    checkOutput("lo_rts_still_down", 32'(rts), 32'd0);
    @(negedge clk);
    checkOutput("lo_rts_up", 32'(rts), 32'd1);
    drainAll("lo_drain");

    // Overrun: 17th word dropped, push+pop at full keeps count at 16
    for (int i = 0; i < 17; i++) applyStimulus(8'(8'h40 + i), 3'b000, 1);
    checkOutput("ovr_count", 32'(fifoCount), 32'd16);
    checkStatus("ovr");
    head = sbQ.pop_front();
    checkOutput("ovr_pp_head", 32'(hostData), 32'(head[7:0]));
    rxData = 8'hEE; rxErr = 3'b000; dataRdy = 1'b1; hostReady = 1'b1;
    modelCapture(8'hEE, 3'b000, 1'b1);
    @(negedge clk);
    dataRdy = 1'b0; hostReady = 1'b0;
    checkOutput("ovr_pp_count", 32'(fifoCount), 32'd16);
    checkStatus("ovr_pp");
    @(negedge clk);
    drainAll("ovr_drain");

    // Errors and status clear
    clrStatus = 1'b1;
    modelFlags = '0; modelErrCnt = 0; modelDropCnt = 0; modelOverrun = 1'b0;
    @(negedge clk);
    clrStatus = 1'b0;
    checkStatus("clr");
    applyStimulus(8'h01, 3'b010, 1);
    applyStimulus(8'h02, 3'b100, 2);
    applyStimulus(8'h03, 3'b000, 1);
    checkOutput("err_flags", 32'(errFlags), 32'h6);
    checkOutput("err_count", 32'(errCount), 32'd2);
    drainAll("err_pop");
    clrStatus = 1'b1;
    rxData = 8'h77; rxErr = 3'b001; dataRdy = 1'b1;
    modelFlags = '0; modelErrCnt = 0; modelDropCnt = 0; modelOverrun = 1'b0;
    modelCapture(8'h77, 3'b001, 1'b0);
    @(negedge clk);
    clrStatus = 1'b0; dataRdy = 1'b0;
    checkOutput("clrcap_flags", 32'(errFlags), 32'h1);
    checkOutput("clrcap_count", 32'(errCount), 32'd1);
    checkStatus("clrcap");
    @(negedge clk);
    drainAll("clrcap_pop");

    // Wraparound stream, then reset with words queued
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1);
      if (sbQ.size() >= 3) popAndCheck("wrap_pop");
    end
    drainAll("wrap_drain");
    checkStatus("wrap");
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'hC0 + i), 3'b000, 1);
    checkOutput("mid_count_5", 32'(fifoCount), 32'd5);
    rst = 1'b1;
    hostReady = 1'b1;
    @(negedge clk);
    sbQ.delete();
    modelFlags = '0; modelErrCnt = 0; modelDropCnt = 0; modelOverrun = 1'b0;
    checkOutput("mid_rst_count", 32'(fifoCount), 32'd0);
    checkOutput("mid_rst_valid", 32'(hostValid), 32'd0);
    checkOutput("mid_rst_rts", 32'(rts), 32'd0);
    checkStatus("mid_rst");
    rst = 1'b0;
    hostReady = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
